// File: rtl/pwm_pkg.sv
// Shared widths, channel-mode encoding and the per-channel output rule
// for the sixteen-channel PWM peripheral.
package pwm_pkg;

  localparam int PWM_CNT_W    = 8;
  localparam int PWM_CHANNELS = 16;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    STATIC = 2'd1,
    MOD    = 2'd2
  } chan_mode_e;

  // Output enable dominates; PWM select only matters for enabled channels.
  function automatic chan_mode_e chan_mode(input logic en_out, input logic en_pwm);
    if (!en_out)
      return OFF;
    else if (!en_pwm)
      return STATIC;
    else
      return MOD;
  endfunction

  function automatic logic chan_level(input chan_mode_e mode,
                                      input logic [PWM_CNT_W-1:0] cnt,
                                      input logic [PWM_CNT_W-1:0] duty);
    case (mode)
      STATIC:  return 1'b1;
      // Full-scale duty must never drop, even on the last count of the period.
      MOD:     return (duty == DUTY_FULL) || (cnt < duty);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler and free-running 8-bit PWM counter; exports the counter value
// and a strobe that marks the cycle before the counter wraps 255 -> 0.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] o_pwm_cnt,
  output logic                 o_wrap
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]     r_pre_cnt;
  logic [PWM_CNT_W-1:0] r_pwm_cnt;
  logic                 w_tick;

  assign w_tick = (r_pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick)
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign o_pwm_cnt = r_pwm_cnt;
  assign o_wrap    = w_tick && (r_pwm_cnt == {PWM_CNT_W{1'b1}});

endmodule

// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM output stage with a shared period and duty cycle.
// Define PWM_DUTY_SHADOW_EN to latch the duty value only at period start.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic [PWM_CNT_W-1:0]    w_pwm_cnt;
  logic                    w_wrap;
  logic [PWM_CHANNELS-1:0] w_en_out;
  logic [PWM_CHANNELS-1:0] w_en_pwm;
  logic [PWM_CNT_W-1:0]    w_duty_a;
  logic [PWM_CHANNELS-1:0] w_out_next;
  logic [PWM_CHANNELS-1:0] r_out;
  logic                    r_period_start;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .o_pwm_cnt (w_pwm_cnt),
    .o_wrap    (w_wrap)
  );

  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_DUTY_SHADOW_EN
  logic [PWM_CNT_W-1:0] r_duty_shadow;

  // Loaded on the wrap cycle so each period runs at one duty value.
  always_ff @(posedge clk) begin
    if (rst)
      r_duty_shadow <= '0;
    else if (w_wrap)
      r_duty_shadow <= pwm_duty_cycle;
  end

  assign w_duty_a = r_duty_shadow;
`else
  assign w_duty_a = pwm_duty_cycle;
`endif

  generate
    for (genvar gi = 0; gi < PWM_CHANNELS; gi++) begin : g_chan
      assign w_out_next[gi] = chan_level(chan_mode(w_en_out[gi], w_en_pwm[gi]),
                                         w_pwm_cnt, w_duty_a);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_out          <= w_out_next;
      r_period_start <= w_wrap;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at PRESCALE=13 (3328-cycle period);
// expectations adapt to PWM_DUTY_SHADOW_EN for the mid-period duty write.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int tests = 0;
  int fails = 0;
  int k = 0;
  int found, bad;
  int hi0, hi1, hi15, lo0, even_bad, odd_split, ps_cnt, fall_k;
  logic first_val;

`ifdef PWM_DUTY_SHADOW_EN
  localparam int   SHD_REST_HI = 0;
  localparam logic SHD_FIRST   = 1'b0;
`else
  localparam int   SHD_REST_HI = 92 * 13;
  localparam logic SHD_FIRST   = 1'b1;
`endif

  pwm_peripheral #(.PRESCALE(13)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
    $display("[TB] check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // k counts clock edges since reset release; sampling 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  task automatic run_window(input int n);
    logic prev;
    prev = 1'b0;
    hi0 = 0; hi1 = 0; hi15 = 0; lo0 = 0;
    even_bad = 0; odd_split = 0; ps_cnt = 0; fall_k = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0)
        first_val = out[0];
      else if (prev && !out[0] && fall_k == 0)
        fall_k = k;
      prev = out[0];
      if (out[0] === 1'b1) hi0++;
      if (out[0] !== 1'b1) lo0++;
      if (out[1] === 1'b1) hi1++;
      if (out[15] === 1'b1) hi15++;
      if ((out & 16'h5555) !== 16'h5555) even_bad++;
      if ((out & 16'hAAAA) !== 16'h0000 && (out & 16'hAAAA) !== 16'hAAAA) odd_split++;
      if (period_start === 1'b1) ps_cnt++;
    end
  endtask

  task automatic wait_period_start(input int limit);
    found = 0;
    while (k < limit && found == 0) begin
      step();
      if (period_start === 1'b1) found = k;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out", out, 16'h0000);
      check("rst_ps", period_start, 0);
    end

    rst = 1'b0;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;
    k = 0;
    step_to(2);
    check("off_out", out, 16'h0000);

    // Static high on channel 0; duty pre-set for the modulation phase.
    set_en(16'h0001, 16'h0000);
    pwm_duty_cycle = 8'd128;
    step();
    check("static_first", out, 16'h0001);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out !== 16'h0001) bad++;
    end
    check("static_hold", bad, 0);

    wait_period_start(4000);
    check("first_ps_cycle", found, 3328);
    step_to(3328);

    // Duty 128: high for 128*13 cycles, falling at counter value 128.
    set_en(16'h0001, 16'h0001);
    run_window(3328);
    check("mod_first_high", first_val, 1);
    check("mod_high_cnt", hi0, 1664);
    check("mod_fall_k", fall_k, 4993);
    check("mod_ps_cnt", ps_cnt, 1);
    check("mod_ps_at_end", period_start, 1);

    pwm_duty_cycle = 8'd0;
    step_to(9984);
    run_window(3328);
    check("duty0_high", hi0, 0);
    check("duty0_ps", ps_cnt, 1);

    pwm_duty_cycle = 8'd255;
    step_to(16640);
    run_window(6656);
    check("duty255_low", lo0, 0);
    check("duty255_ps", ps_cnt, 2);

    set_en(16'hFFFF, 16'hAAAA);
    pwm_duty_cycle = 8'd64;
    step_to(26624);
    run_window(3328);
    check("mixed_even", even_bad, 0);
    check("mixed_ch1_hi", hi1, 832);
    check("mixed_ch15_hi", hi15, 832);
    check("mixed_odd_eq", odd_split, 0);
    set_en(16'h0000, 16'hAAAA);
    step();
    check("mixed_off", out, 16'h0000);

    // Duty 64 -> 192 written while the counter sits at 100.
    set_en(16'h0001, 16'h0001);
    step_to(31252);
    check("shd_before", out[0], 0);
    pwm_duty_cycle = 8'd192;
    run_window(2028);
    check("shd_rerise", first_val, SHD_FIRST);
    check("shd_rest_hi", hi0, SHD_REST_HI);
    check("shd_rest_ps", ps_cnt, 1);
    run_window(3328);
    check("shd_next_first", first_val, 1);
    check("shd_next_hi", hi0, 2496);

    // Reset in the middle of a period restarts the counters from zero.
    step_to(37000);
    rst = 1'b1;
    set_en(16'h0000, 16'h0000);
    step();
    check("midrst_out", out, 16'h0000);
    check("midrst_ps", period_start, 0);
    rst = 1'b0;
    k = 0;
    wait_period_start(4000);
    check("midrst_first_ps", found, 3328);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
